// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: per-digit blanking + display windows, one frame
// snapshot of the hex word, leading-zero suppression and decimal point merge.
module display_scanner #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [3:0]              nibble,
    input  logic [8:0]              seg_in,
    output logic [8:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(TICKS_PER_DIGIT);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                       state;
    logic [IW-1:0]                idx;
    logic [CW-1:0]                cnt;
    logic [NUM_DIGITS-1:0][3:0]   snap;
    logic [NUM_DIGITS-1:0]        dp_snap;
    logic                         lz_snap;
    logic [NUM_DIGITS-1:0]        supp;
    logic [NUM_DIGITS-1:0]        onehot;
    logic                         frame_edge;
    logic                         zero_run;

    assign nibble     = snap[idx];
    assign frame_edge = (state == BLANK) && (idx == '0) && (cnt == '0);

    // A digit is suppressed when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap[i] == 4'd0);
            supp[i]  = lz_snap && (i != 0) && zero_run;
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            snap        <= '0;
            dp_snap     <= '0;
            lz_snap     <= 1'b0;
            seg_out     <= '0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            if (frame_edge) begin
                snap    <= value;
                dp_snap <= dp_mask;
                lz_snap <= lz_blank;
            end

            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase

            // Outputs reflect the state of the cycle just ending.
            if (state == SHOW) begin
                if (supp[idx]) begin
                    seg_out  <= {1'b0, dp_snap[idx], 7'b0};
                    digit_en <= dp_snap[idx] ? onehot : '0;
                end else begin
                    seg_out  <= {seg_in[8], seg_in[7] | dp_snap[idx], seg_in[6:0]};
                    digit_en <= onehot;
                end
            end else begin
                seg_out  <= '0;
                digit_en <= '0;
            end
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with a 4-digit, 4-tick, 1-blank scan.
module tb_display_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  nibble;
    logic [8:0]  seg_in;
    logic [8:0]  seg_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int passed = 0;
    int total  = 0;

    display_scanner #(.NUM_DIGITS(4), .TICKS_PER_DIGIT(4), .BLANK_TICKS(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask), .lz_blank(lz_blank),
        .nibble(nibble), .seg_in(seg_in), .seg_out(seg_out), .digit_en(digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 9'h03F; 4'h1: dec = 9'h006; 4'h2: dec = 9'h05B; 4'h3: dec = 9'h04F;
            4'h4: dec = 9'h066; 4'h5: dec = 9'h06D; 4'h6: dec = 9'h07D; 4'h7: dec = 9'h007;
            4'h8: dec = 9'h07F; 4'h9: dec = 9'h06F; 4'hA: dec = 9'h077; 4'hB: dec = 9'h07C;
            4'hC: dec = 9'h039; 4'hD: dec = 9'h05E; 4'hE: dec = 9'h079; default: dec = 9'h071;
        endcase
    endfunction

    always_comb seg_in = dec(nibble);

    // Checks one 16-cycle frame starting at the current (frame_start) negedge;
    // optionally applies new inputs at cycle chg_k. Ends at the next frame start.
    task automatic check_frame(input string name, input logic [3:0][8:0] es,
                               input logic [3:0][3:0] ee, input int chg_k,
                               input logic [15:0] nv, input logic [3:0] nd, input logic nl);
        logic [8:0] xs;
        logic [3:0] xe;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            xs = (k % 4 == 0) ? 9'h000 : es[k / 4];
            xe = (k % 4 == 0) ? 4'b0000 : ee[k / 4];
            total++;
            if (seg_out !== xs || digit_en !== xe || frame_start !== (k == 0))
                $display("FAIL %s k=%0d: seg=%h en=%b fs=%b, expected seg=%h en=%b fs=%b",
                         name, k, seg_out, digit_en, frame_start, xs, xe, (k == 0));
            else passed++;
            if (k == chg_k) begin
                value = nv; dp_mask = nd; lz_blank = nl;
            end
        end
        @(negedge clk);
    endtask

    localparam logic [3:0][3:0] EN_ALL = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [3:0][8:0] S_12AF = {9'h006, 9'h05B, 9'h077, 9'h071};
    localparam logic [3:0][8:0] S_3456 = {9'h04F, 9'h066, 9'h06D, 9'h07D};

    task automatic test_reset();
        rst = 1'b1; value = 16'h12AF; dp_mask = 4'b0; lz_blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (seg_out !== 9'h0 || digit_en !== 4'b0 || frame_start !== 1'b0)
                $display("FAIL reset_hold: seg=%h en=%b fs=%b, expected all 0",
                         seg_out, digit_en, frame_start);
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1)
            $display("FAIL reset_release_fs: fs=%b, expected 1", frame_start);
        else passed++;
    endtask

    task automatic test_scan_order();
        check_frame("scan_f1", S_12AF, EN_ALL, -1, 16'h0, 4'b0, 1'b0);
        check_frame("scan_f2", S_12AF, EN_ALL, -1, 16'h0, 4'b0, 1'b0);
    endtask

    task automatic test_tear_free();
        check_frame("tear_old", S_12AF, EN_ALL, 6, 16'h3456, 4'b0, 1'b0);
        check_frame("tear_new", S_3456, EN_ALL, 1, 16'h0070, 4'b0100, 1'b1);
    endtask

    task automatic test_lz_dp();
        check_frame("lz_dp", {9'h000, 9'h080, 9'h007, 9'h03F},
                    {4'b0000, 4'b0100, 4'b0010, 4'b0001}, 1, 16'h0000, 4'b0, 1'b1);
    endtask

    task automatic test_all_zero();
        check_frame("all_zero", {9'h000, 9'h000, 9'h000, 9'h03F},
                    {4'b0000, 4'b0000, 4'b0000, 4'b0001}, 1, 16'h12AF, 4'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (digit_en !== 4'b0100 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (digit_en !== 4'b0100)
            $display("FAIL rstmid_wait: en=%b, expected 0100 within 20 cycles", digit_en);
        else passed++;
        rst = 1'b1; value = 16'h3456;
        @(negedge clk);
        total++;
        if (seg_out !== 9'h0 || digit_en !== 4'b0 || frame_start !== 1'b0)
            $display("FAIL rstmid_zero: seg=%h en=%b fs=%b, expected all 0",
                     seg_out, digit_en, frame_start);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        check_frame("rstmid_frame", S_3456, EN_ALL, -1, 16'h0, 4'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_lz_dp();
        test_all_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
